// File: rtl/ram_arb_pkg.sv
// Shared types and address-window constants for the two-port RAM arbiter.
package ram_arb_pkg;

   typedef enum logic {IDLE, ISSUE} arb_state_t;
   typedef logic port_idx_t;

   localparam logic [31:0] DATA_BASE   = 32'h0000_1000;
   localparam logic [31:0] DATA_END    = 32'h0000_3000;
   localparam logic [31:0] UART_ADDR   = 32'h0000_4000;
   localparam logic [31:0] STACK_TOP   = 32'hFFFF_FFFC;
   localparam int          STACK_WORDS = 10;
   localparam logic [31:0] STACK_BASE  = STACK_TOP - 32'(4 * (STACK_WORDS - 1));

   function automatic logic [1:0] port_onehot(input port_idx_t p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram_arb_addr_check.sv
// Combinational legality decode for one RAM access: aligned and inside an allowed window.
module ram_arb_addr_check
   import ram_arb_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] addr,
   input  logic          we,
   output logic          legal
);

   logic [31:0] a;
   logic        aligned, in_data, is_uart, in_stack;

   assign a        = 32'(addr);
   assign aligned  = (a[1:0] == 2'b00);
   assign in_data  = (a >= DATA_BASE) && (a < DATA_END);
   assign is_uart  = (a == UART_ADDR) && !we;   // UART window is read only
   assign in_stack = (a >= STACK_BASE) && (a <= STACK_TOP);
   assign legal    = aligned && (in_data || is_uart || in_stack);

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single RAM port: fixed priority to port 0 with a port 1 anti-starvation counter.
// Defining ARB_ADDR_CHECK_EN adds err_o and blocks writes/reads outside the legal address windows.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req_i,
   input  logic [1:0]    we_i,
   input  logic [AW-1:0] addr_i  [2],
   input  logic [DW-1:0] wdata_i [2],
   output logic [1:0]    gnt_o,
   output logic [1:0]    rvalid_o,
   output logic [DW-1:0] rdata_o,
`ifdef ARB_ADDR_CHECK_EN
   output logic [1:0]    err_o,
`endif
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
);

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   arb_state_t state;
   port_idx_t  win, cur;
   logic [3:0] wait_cnt;
   logic       win_legal, cur_illegal;

   // Port 1 wins when it is the only requester or has waited MAX_WAIT arbitrations.
   always_comb begin
      win = 1'b0;
      if (req_i[1] && (wait_cnt == WAIT_MAX || !req_i[0]))
         win = 1'b1;
   end

`ifdef ARB_ADDR_CHECK_EN
   ram_arb_addr_check #(.AW(AW)) u_addr_check (
      .addr  (addr_i[win]),
      .we    (we_i[win]),
      .legal (win_legal)
   );
`else
   assign win_legal = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cur         <= 1'b0;
         cur_illegal <= 1'b0;
         wait_cnt    <= '0;
         gnt_o       <= '0;
         rvalid_o    <= '0;
         rdata_o     <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
`ifdef ARB_ADDR_CHECK_EN
         err_o       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               rvalid_o <= '0;
               mem_we_o <= 1'b0;
`ifdef ARB_ADDR_CHECK_EN
               err_o    <= '0;
`endif
               if (req_i[1] && !win)
                  wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 4'd1;
               else
                  wait_cnt <= '0;
               if (|req_i) begin
                  state       <= ISSUE;
                  cur         <= win;
                  cur_illegal <= !win_legal;
                  gnt_o       <= port_onehot(win);
                  mem_we_o    <= we_i[win] && win_legal;
                  mem_addr_o  <= addr_i[win];
                  mem_wdata_o <= wdata_i[win];
               end
            end
            ISSUE: begin
               state    <= IDLE;
               gnt_o    <= '0;
               mem_we_o <= 1'b0;
               rvalid_o <= port_onehot(cur);
               rdata_o  <= cur_illegal ? '1 : mem_rdata_i;
`ifdef ARB_ADDR_CHECK_EN
               err_o    <= cur_illegal ? port_onehot(cur) : 2'b00;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: vector table for single-port sequences plus hand-written arbitration and reset sequences.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_i, we_i;
   logic [31:0] addr_i  [2];
   logic [31:0] wdata_i [2];
   logic [1:0]  gnt_o, rvalid_o;
   logic [31:0] rdata_o;
`ifdef ARB_ADDR_CHECK_EN
   logic [1:0]  err_o;
`endif
   logic        mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   logic [31:0] ram [1024] = '{default: 32'h0};

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
`ifdef ARB_ADDR_CHECK_EN
      .err_o       (err_o),
`endif
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   // RAM: write on falling edge, combinational read, UART data register at 0x4000.
   always @(negedge clk)
      if (mem_we_o) ram[mem_addr_o[11:2]] <= mem_wdata_o;
   assign mem_rdata_i = (mem_addr_o == 32'h4000) ? 32'h41 : ram[mem_addr_o[11:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [31:0] addr0;
      logic [31:0] wdata0;
      logic [31:0] addr1;
      logic [1:0]  gnt;
      logic [1:0]  rvalid;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic        chk_rd;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [12];

   // Hold req until n grants are seen; exp bit i = port expected for grant i.
   task automatic run_grants(input logic [1:0] req, input int n, input logic [9:0] exp, input string name);
      int got = 0;
      int cyc = 0;
      req_i = req;
      while (got < n && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         chk({name, "_gnt_unrequested"}, 32'(gnt_o & ~req), 32'h0);
         if (!req[1]) chk({name, "_rvalid1"}, 32'(rvalid_o[1]), 32'h0);
         if (gnt_o != 2'b00) begin
            chk($sformatf("%s_grant%0d", name, got), 32'(gnt_o), exp[got] ? 32'h2 : 32'h1);
            got++;
         end
      end
      if (got < n) chk({name, "_timeout"}, 32'(got), 32'(n));
   endtask

   task automatic single_access(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_err, input string name);
      logic [1:0] oh;
      oh = (p == 1) ? 2'b10 : 2'b01;
      req_i = 2'b00;
      we_i[p] = we;
      addr_i[p] = a;
      wdata_i[p] = wd;
      req_i[p] = 1'b1;
      @(posedge clk); #1;
      chk({name, "_gnt"}, 32'(gnt_o), 32'(oh));
      chk({name, "_mem_we"}, 32'(mem_we_o), 32'(we && !exp_err));
      chk({name, "_mem_addr"}, mem_addr_o, a);
      req_i = 2'b00;
      @(posedge clk); #1;
      chk({name, "_rvalid"}, 32'(rvalid_o), 32'(oh));
      chk({name, "_mem_we_idle"}, 32'(mem_we_o), 32'h0);
      if (!we || exp_err) chk({name, "_rdata"}, rdata_o, exp_rd);
`ifdef ARB_ADDR_CHECK_EN
      chk({name, "_err"}, 32'(err_o), exp_err ? 32'(oh) : 32'h0);
`endif
      @(posedge clk); #1;
      chk({name, "_rvalid_clr"}, 32'(rvalid_o), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      //          req    we     addr0         wdata0        addr1         gnt    rv     mwe   mem_addr      chk   rdata
      vecs[0]  = '{2'b01, 2'b01, 32'h1000, 32'hDEADBEEF, 32'h0,    2'b01, 2'b00, 1'b1, 32'h1000, 1'b0, 32'h0};
      vecs[1]  = '{2'b01, 2'b01, 32'h1000, 32'hDEADBEEF, 32'h0,    2'b00, 2'b01, 1'b0, 32'h1000, 1'b0, 32'h0};
      vecs[2]  = '{2'b01, 2'b00, 32'h1000, 32'h0,        32'h0,    2'b01, 2'b00, 1'b0, 32'h1000, 1'b0, 32'h0};
      vecs[3]  = '{2'b00, 2'b00, 32'h1000, 32'h0,        32'h0,    2'b00, 2'b01, 1'b0, 32'h1000, 1'b1, 32'hDEADBEEF};
      vecs[4]  = '{2'b00, 2'b00, 32'h1000, 32'h0,        32'h0,    2'b00, 2'b00, 1'b0, 32'h1000, 1'b0, 32'h0};
      vecs[5]  = '{2'b10, 2'b00, 32'h0,    32'h0,        32'h4000, 2'b10, 2'b00, 1'b0, 32'h4000, 1'b0, 32'h0};
      vecs[6]  = '{2'b10, 2'b00, 32'h0,    32'h0,        32'h4000, 2'b00, 2'b10, 1'b0, 32'h4000, 1'b1, 32'h41};
      vecs[7]  = '{2'b10, 2'b00, 32'h0,    32'h0,        32'h4000, 2'b10, 2'b00, 1'b0, 32'h4000, 1'b0, 32'h0};
      vecs[8]  = '{2'b10, 2'b00, 32'h0,    32'h0,        32'h4000, 2'b00, 2'b10, 1'b0, 32'h4000, 1'b1, 32'h41};
      vecs[9]  = '{2'b10, 2'b00, 32'h0,    32'h0,        32'h4000, 2'b10, 2'b00, 1'b0, 32'h4000, 1'b0, 32'h0};
      vecs[10] = '{2'b00, 2'b00, 32'h0,    32'h0,        32'h4000, 2'b00, 2'b10, 1'b0, 32'h4000, 1'b1, 32'h41};
      vecs[11] = '{2'b00, 2'b00, 32'h0,    32'h0,        32'h4000, 2'b00, 2'b00, 1'b0, 32'h4000, 1'b0, 32'h0};

      rst = 1'b1;
      req_i = 2'b00;
      we_i = 2'b00;
      addr_i[0] = 32'h0; addr_i[1] = 32'h0;
      wdata_i[0] = 32'h0; wdata_i[1] = 32'h0;
      #12;
      chk("rst_gnt", 32'(gnt_o), 32'h0);
      chk("rst_rvalid", 32'(rvalid_o), 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_mem_we", 32'(mem_we_o), 32'h0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_mem_wdata", mem_wdata_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Port 0 write/read, then port 1 back-to-back UART reads.
      for (int i = 0; i < 12; i++) begin
         req_i      = vecs[i].req;
         we_i       = vecs[i].we;
         addr_i[0]  = vecs[i].addr0;
         wdata_i[0] = vecs[i].wdata0;
         addr_i[1]  = vecs[i].addr1;
         wdata_i[1] = 32'h0;
         @(posedge clk); #1;
         chk($sformatf("v%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].gnt));
         chk($sformatf("v%0d_rvalid", i), 32'(rvalid_o), 32'(vecs[i].rvalid));
         chk($sformatf("v%0d_mem_we", i), 32'(mem_we_o), 32'(vecs[i].mem_we));
         chk($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].mem_addr);
         if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].rdata);
      end

      // Both ports requesting continuously: port 1 wins every fifth grant.
      we_i = 2'b00;
      addr_i[0] = 32'h1000;
      addr_i[1] = 32'h4000;
      run_grants(2'b11, 10, 10'b10_0001_0000, "starve");
      req_i = 2'b00;
      repeat (3) @(posedge clk);
      #1;

      // Port 1 loses three times then drops: its wait count must restart from zero.
      run_grants(2'b11, 3, 10'b0, "lose3");
      run_grants(2'b01, 1, 10'b0, "drop1");
      run_grants(2'b11, 5, 10'b00_0001_0000, "restart");
      req_i = 2'b00;
      repeat (3) @(posedge clk);
      #1;

      // Reset during the ISSUE cycle of a write aborts it.
      we_i[0] = 1'b1;
      addr_i[0] = 32'h1004;
      wdata_i[0] = 32'h12345678;
      req_i = 2'b01;
      @(posedge clk); #1;
      chk("rstmid_gnt_before", 32'(gnt_o), 32'h1);
      chk("rstmid_mem_we_before", 32'(mem_we_o), 32'h1);
      rst = 1'b1;
      #1;
      chk("rstmid_gnt", 32'(gnt_o), 32'h0);
      chk("rstmid_mem_we", 32'(mem_we_o), 32'h0);
      chk("rstmid_mem_addr", mem_addr_o, 32'h0);
      chk("rstmid_mem_wdata", mem_wdata_o, 32'h0);
      chk("rstmid_rdata", rdata_o, 32'h0);
      req_i = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("rstmid_no_rvalid%0d", i), 32'(rvalid_o), 32'h0);
      end
      single_access(0, 1'b0, 32'h1004, 32'h0, 32'h0, 1'b0, "post_rst_rd");

`ifdef ARB_ADDR_CHECK_EN
      single_access(0, 1'b1, 32'h4000, 32'h55, 32'hFFFFFFFF, 1'b1, "ill_wr_uart");
      single_access(0, 1'b0, 32'h3000, 32'h0, 32'hFFFFFFFF, 1'b1, "ill_rd_3000");
      single_access(1, 1'b0, 32'h4000, 32'h0, 32'h41, 1'b0, "ok_rd_uart");
      single_access(0, 1'b1, 32'hFFFFFFD8, 32'hCAFE, 32'h0, 1'b0, "ok_wr_stack");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
